// File: rtl/ber_monitor.sv
// Bit-error-rate statistics accumulator for the GBS20 receive path.
// Counts aligned words, error bits, worst per-word error count and lock-loss
// events over a programmable window. Registered outputs follow the control
// state one cycle later, so results and `done` appear one cycle after DONE.
module ber_monitor #(
    parameter int unsigned SETTLE = 16,
    parameter int unsigned WIN_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIN_W-1:0] windowLen,
    input  logic             aligned,
    input  logic [31:0]      errorBits,
    output logic             busy,
    output logic             done,
    output logic             resultValid,
    output logic [47:0]      wordCount,
    output logic [39:0]      errCount,
    output logic [5:0]       maxWordErr,
    output logic [7:0]       lockLoss
);

    localparam int unsigned MASK_W    = 32;
    localparam int unsigned WORD_W    = 48;
    localparam int unsigned ERR_W     = 40;
    localparam int unsigned ERR_EXT_W = ERR_W + 1;
    localparam int unsigned POP_W     = 6;
    localparam int unsigned LOSS_W    = 8;
    localparam int unsigned SET_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        MEASURE,
        DRAIN,
        DONE
    } stateT;

    stateT              state, nextState;
    logic [SET_W-1:0]   settleCnt, settleNext;
    logic [WIN_W-1:0]   winLen, acceptCnt, acceptNext;
    logic               accept, lossInc, clearWork;
    logic [MASK_W-1:0]  s1Mask;
    logic               s1Valid;
    logic [POP_W-1:0]   popCnt;
    logic [ERR_EXT_W-1:0] errSum;
    logic [WORD_W-1:0]  wordAcc, wordNext;
    logic [ERR_W-1:0]   errAcc, errNext;
    logic [POP_W-1:0]   maxAcc, maxNext;
    logic [LOSS_W-1:0]  lossAcc, lossNext;

    // Control state, settle/accept counters and stage-1 capture register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            settleCnt <= '0;
            acceptCnt <= '0;
            winLen    <= '0;
            s1Mask    <= '0;
            s1Valid   <= 1'b0;
        end else begin
            state     <= nextState;
            settleCnt <= settleNext;
            acceptCnt <= acceptNext;
            s1Valid   <= accept;
            if (clearWork) winLen <= windowLen;
            if (accept)    s1Mask <= errorBits;
        end
    end

    // Next-state decode: lock settling, word acceptance, window end and stop
    always_comb begin
        nextState  = state;
        settleNext = settleCnt;
        acceptNext = acceptCnt;
        accept     = 1'b0;
        lossInc    = 1'b0;
        clearWork  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    clearWork  = 1'b1;
                    settleNext = '0;
                    acceptNext = '0;
                    nextState  = WAIT_LOCK;
                end else if (state == DONE) begin
                    nextState = IDLE;
                end
            end
            WAIT_LOCK: begin
                if (aligned) settleNext = settleCnt + SET_W'(1);
                else         settleNext = '0;
                if (stop)                                              nextState = DRAIN;
                else if (aligned && settleCnt == SET_W'(SETTLE - 1))   nextState = MEASURE;
            end
            MEASURE: begin
                if (aligned) begin
                    accept     = 1'b1;
                    acceptNext = acceptCnt + WIN_W'(1);
                    if (stop || (winLen != '0 && acceptNext == winLen)) nextState = DRAIN;
                end else begin
                    lossInc    = 1'b1;
                    settleNext = '0;
                    nextState  = stop ? DRAIN : WAIT_LOCK;
                end
            end
            DRAIN:   nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Stage 2: popcount of the captured mask folded into the working counters
    always_comb begin
        popCnt = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            popCnt = popCnt + POP_W'(s1Mask[i]);
        end
        errSum   = {1'b0, errAcc} + ERR_EXT_W'(popCnt);
        wordNext = wordAcc;
        errNext  = errAcc;
        maxNext  = maxAcc;
        lossNext = lossAcc;
        if (s1Valid) begin
            wordNext = wordAcc + WORD_W'(1);
            errNext  = errSum[ERR_W] ? '1 : errSum[ERR_W-1:0];
            if (popCnt > maxAcc) maxNext = popCnt;
        end
        if (lossInc && lossAcc != '1) lossNext = lossAcc + LOSS_W'(1);
        if (clearWork) begin
            wordNext = '0;
            errNext  = '0;
            maxNext  = '0;
            lossNext = '0;
        end
    end

    // Working counters, reloaded every cycle from their next values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wordAcc <= '0;
            errAcc  <= '0;
            maxAcc  <= '0;
            lossAcc <= '0;
        end else begin
            wordAcc <= wordNext;
            errAcc  <= errNext;
            maxAcc  <= maxNext;
            lossAcc <= lossNext;
        end
    end

    // Published outputs: status flags and a result snapshot taken in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            resultValid <= 1'b0;
            wordCount   <= '0;
            errCount    <= '0;
            maxWordErr  <= '0;
            lockLoss    <= '0;
        end else begin
            busy <= (state == WAIT_LOCK) || (state == MEASURE) || (state == DRAIN);
            done <= (state == DONE);
            if (state == DONE) begin
                resultValid <= 1'b1;
                wordCount   <= wordAcc;
                errCount    <= errAcc;
                maxWordErr  <= maxAcc;
                lockLoss    <= lossAcc;
            end else if (state == WAIT_LOCK) begin
                resultValid <= 1'b0;
            end
        end
    end

endmodule
